// File: rtl/timer_device_if.sv
// Processor-bus view of the countdown timer: word select, write strobe,
// write data, combinational read data and the interrupt line.
interface timer_device_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    // CPU / bridge side drives the bus and observes read data and IRQ
    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout,
        input  IRQ
    );

    // Timer side consumes the bus and returns read data and IRQ
    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout,
        output IRQ
    );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with CTRL / PRESET / COUNT registers, a
// four-state counting FSM and a level interrupt gated by CTRL.IM.
module timer_device #(
    parameter int COUNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         ctrl;
    logic [3:0]         ctrl_nxt;
    logic [COUNT_W-1:0] preset;
    logic [COUNT_W-1:0] preset_nxt;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nxt;
    logic               irq_flag;
    logic               irq_flag_nxt;

    logic en;
    logic auto_reload;
    logic irq_mask;
    logic ctrl_wr;
    logic preset_wr;
    logic count_gt1;

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign irq_mask    = ctrl[3];
    assign ctrl_wr     = bus.WE && (bus.Addr == 2'd0);
    assign preset_wr   = bus.WE && (bus.Addr == 2'd1);
    assign count_gt1   = (count > COUNT_W'(1));

    // State register; reset returns the FSM to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic of the counting FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = LOAD;
            LOAD:    state_nxt = CNT;
            CNT: begin
                if (!en)            state_nxt = IDLE;
                else if (!count_gt1) state_nxt = INT;
            end
            INT:     state_nxt = auto_reload ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register update values: FSM actions first, then software writes;
    // the expiry set of irq_flag is applied last so it beats a CTRL-write clear
    always_comb begin
        ctrl_nxt     = ctrl;
        preset_nxt   = preset;
        count_nxt    = count;
        irq_flag_nxt = irq_flag;

        if (state == INT) begin
            if (auto_reload) irq_flag_nxt = 1'b0;
            else             ctrl_nxt[0]  = 1'b0;
        end

        if (ctrl_wr) begin
            ctrl_nxt     = bus.Din[3:0];
            irq_flag_nxt = 1'b0;
        end

        if (preset_wr) begin
            preset_nxt = bus.Din[COUNT_W-1:0];
        end

        case (state)
            LOAD: count_nxt = preset;
            CNT: begin
                if (en) begin
                    if (count_gt1) begin
                        count_nxt = count - COUNT_W'(1);
                    end else begin
                        count_nxt    = '0;
                        irq_flag_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Software-visible registers and the interrupt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            ctrl     <= ctrl_nxt;
            preset   <= preset_nxt;
            count    <= count_nxt;
            irq_flag <= irq_flag_nxt;
        end
    end

    // Zero-extended read mux; the unused word reads as zero
    always_comb begin
        case (bus.Addr)
            2'd0:    bus.Dout = {28'd0, ctrl};
            2'd1:    bus.Dout = 32'(preset);
            2'd2:    bus.Dout = 32'(count);
            default: bus.Dout = 32'd0;
        endcase
    end

    assign bus.IRQ = irq_flag & irq_mask;

endmodule
